// File: rtl/scroll_rate_ctrl.sv
// Scroll rate stage: key sync/debounce, saturating 5-level speed FSM, and tick generator.
// Optional SCROLL_PAUSE_EN adds a pause input that freezes the rate counters.

module scroll_key_db #(
    parameter int DB_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    logic [1:0]    sync;
    logic          deb;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            deb   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] != deb) begin
                if (cnt == DW'(DB_CYCLES - 1)) begin
                    deb   <= sync[1];
                    cnt   <= '0;
                    // only the 1->0 edge of the debounced key is a press
                    press <= ~sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module scroll_rate_ctrl #(
    parameter int BASE_DIV  = 6250000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    input  logic       clear,
`ifdef SCROLL_PAUSE_EN
    input  logic       pause,
`endif
    output logic       tick,
    output logic [2:0] level
);
    localparam logic [2:0] L0 = 3'd0;
    localparam logic [2:0] L1 = 3'd1;
    localparam logic [2:0] L2 = 3'd2;
    localparam logic [2:0] L3 = 3'd3;
    localparam logic [2:0] L4 = 3'd4;
    localparam int PW = $clog2(BASE_DIV);

    logic [1:0]    key_n;
    logic [1:0]    press;
    logic          up_evt, dn_evt;
    logic          hold;
    logic          base;
    logic          run;
    logic [PW-1:0] pre;
    logic [3:0]    oct;
    logic [3:0]    mask;

`ifdef SCROLL_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign key_n = {key_dn_n, key_up_n};

    for (genvar i = 0; i < 2; i++) begin : g_key
        scroll_key_db #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (CLOCK_50),
            .rst_n (Resetn),
            .key_n (key_n[i]),
            .press (press[i])
        );
    end

    assign up_evt = press[0];
    assign dn_evt = press[1];

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || clear) begin
            level <= L2;
        end else if (up_evt && !dn_evt && level != L4) begin
            level <= level + 3'd1;
        end else if (dn_evt && !up_evt && level != L0) begin
            level <= level - 3'd1;
        end
    end

    // level n fires when the low n octave bits are all ones: every 2^n base pulses
    always_comb begin
        mask = 4'b0000;
        case (level)
            L1:      mask = 4'b0001;
            L2:      mask = 4'b0011;
            L3:      mask = 4'b0111;
            L4:      mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
    end

    assign base = (pre == PW'(BASE_DIV - 1));
    assign run  = !clear && !hold;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || clear) begin
            pre  <= '0;
            oct  <= '0;
            tick <= 1'b0;
        end else if (!run) begin
            tick <= 1'b0;
        end else begin
            tick <= base && ((oct & mask) == mask);
            if (base) begin
                pre <= '0;
                oct <= oct + 4'd1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_scroll_rate_ctrl.sv
// Bench for scroll_rate_ctrl: randomized key presses against a counting reference model.
module tb_scroll_rate_ctrl;
    localparam int BD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       Resetn = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic       clear = 1'b0;
    logic       pause = 1'b0;
    logic       tick;
    logic [2:0] level;

    int checks = 0;
    int failures = 0;

    // reference model: running-edge count since reset/clear, and expected level
    int m = 0;
    bit ran = 0;
    int exp_level = 2;
    bit tick_chk = 0;

    always #5 clk = ~clk;

    scroll_rate_ctrl #(.BASE_DIV(BD), .DB_CYCLES(DB)) dut (
        .CLOCK_50 (clk),
        .Resetn   (Resetn),
        .key_up_n (key_up_n),
        .key_dn_n (key_dn_n),
        .clear    (clear),
`ifdef SCROLL_PAUSE_EN
        .pause    (pause),
`endif
        .tick     (tick),
        .level    (level)
    );

    // one clock: advance the model at the edge, compare tick on the falling edge
    task automatic cyc();
        bit exp_t;
        @(posedge clk);
        if (!Resetn || clear) begin
            m = 0;
            ran = 0;
        end else if (pause) begin
            ran = 0;
        end else begin
            m++;
            ran = 1;
        end
        @(negedge clk);
        if (tick_chk) begin
            exp_t = ran && (m % BD == 0) && (((m / BD) % (1 << exp_level)) == 0);
            checks++;
            if (tick !== exp_t) begin
                failures++;
                $display("FAIL tick_model t=%0t tick=%b expected=%b level_exp=%0d", $time, tick, exp_t, exp_level);
            end
        end
    endtask

    task automatic find_tick(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            cyc();
            if (tick === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic measure_period(input int exp_p, input string name);
        int n1, n2;
        find_tick(300, n1);
        find_tick(300, n2);
        checks++;
        if (n1 < 0 || n2 != exp_p) begin
            failures++;
            $display("FAIL %s period=%0d expected=%0d", name, n2, exp_p);
        end
    endtask

    task automatic check_level(input string name);
        checks++;
        if (level !== 3'(exp_level)) begin
            failures++;
            $display("FAIL %s level=%0d expected=%0d", name, level, exp_level);
        end
    endtask

    task automatic press(input bit up, input bit dn, input int len, input string name);
        tick_chk = 0;
        key_up_n = !up;
        key_dn_n = !dn;
        repeat (len) cyc();
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        repeat (DB + 6 + $urandom_range(0, 5)) cyc();
        if (len >= DB) begin
            if (up && !dn && exp_level < 4) exp_level++;
            else if (dn && !up && exp_level > 0) exp_level--;
        end
        check_level(name);
        tick_chk = 1;
    endtask

    task automatic test_reset();
        int n;
        Resetn = 1'b0;
        repeat (2) cyc();
        checks++;
        if (tick !== 1'b0 || level !== 3'd2) begin
            failures++;
            $display("FAIL reset_state tick=%b level=%0d expected tick=0 level=2", tick, level);
        end
        tick_chk = 1;
        Resetn = 1'b1;
        find_tick(40, n);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL reset_first_tick cycles=%0d expected=16", n);
        end
        measure_period(16, "reset_period");
    endtask

    task automatic test_slow_down();
        for (int i = 0; i < 3; i++) press(1, 0, $urandom_range(DB, 12), "slow_down_level");
        measure_period(64, "level4_period");
    endtask

    task automatic test_clear();
        int n;
        repeat ($urandom_range(0, 20)) cyc();
        clear = 1'b1;
        exp_level = 2;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (tick !== 1'b0) begin
                failures++;
                $display("FAIL clear_no_tick tick=%b expected=0", tick);
            end
        end
        check_level("clear_level");
        clear = 1'b0;
        find_tick(40, n);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL clear_first_tick cycles=%0d expected=16", n);
        end
    endtask

    task automatic test_speed_up();
        int g;
        g = $urandom_range(0, 4);
        for (int i = 0; i < 5; i++) begin
            if (i == g) press(0, 1, $urandom_range(1, DB - 1), "glitch_level");
            press(0, 1, $urandom_range(DB, 12), "speed_up_level");
        end
        press(1, 0, $urandom_range(1, DB - 1), "glitch_up_level");
        measure_period(4, "level0_period");
    endtask

    task automatic test_pause();
        int n;
        repeat ($urandom_range(0, 3)) cyc();
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (tick !== 1'b0) begin
                failures++;
                $display("FAIL pause_no_tick tick=%b expected=0", tick);
            end
        end
        pause = 1'b0;
        find_tick(8, n);
        checks++;
        if (n < 1 || n > 4) begin
            failures++;
            $display("FAIL pause_resume cycles=%0d expected=1..4", n);
        end
    endtask

    task automatic test_simultaneous();
        clear = 1'b1;
        exp_level = 2;
        repeat (3) cyc();
        clear = 1'b0;
        press(1, 1, 10, "simultaneous_level");
        measure_period(16, "simultaneous_period");
    endtask

    task automatic test_mid_reset();
        int n;
        press(0, 1, $urandom_range(DB, 12), "pre_reset_level");
        key_dn_n = 1'b0;
        repeat (3) cyc();
        Resetn = 1'b0;
        exp_level = 2;
        repeat (2) cyc();
        Resetn = 1'b1;
        key_dn_n = 1'b1;
        find_tick(40, n);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL mid_reset_first_tick cycles=%0d expected=16", n);
        end
        repeat (10) cyc();
        check_level("mid_reset_level");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_slow_down();
        test_clear();
        test_speed_up();
`ifdef SCROLL_PAUSE_EN
        test_pause();
`endif
        test_simultaneous();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
